// File: rtl/sort_result_reader.sv
// Streams the sorted result RAM out on a valid/ready port after sort_done, flagging order violations.
// Define SORT_READER_DESC_EN to read the RAM from the top address down and require a non-decreasing stream.
module sort_result_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sort_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              order_err,
  output logic [7:0]        pass_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_HOLD, S_DONE} state_t;

`ifdef SORT_READER_DESC_EN
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_step;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_order_err;
  logic [7:0]          r_pass_cnt;
  logic                w_is_last;
  logic                w_accept;
  logic                w_order_bad;
  logic                w_busy;

  assign w_is_last = (r_idx == LAST_IDX);
  assign w_accept  = r_out_valid & out_ready;

`ifdef SORT_READER_DESC_EN
  assign w_idx_step  = r_idx - ADDR_W'(1);
  assign w_order_bad = (rd_data < r_out_data);
`else
  assign w_idx_step  = r_idx + ADDR_W'(1);
  assign w_order_bad = (rd_data > r_out_data);
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: if (sort_done) w_state_next = S_READ;
      S_READ: begin
        w_busy       = 1'b1;
        w_state_next = S_CAPT;
      end
      S_CAPT: begin
        w_busy       = 1'b1;
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (w_accept) w_state_next = w_is_last ? S_DONE : S_READ;
      end
      S_DONE: if (!sort_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // rd_en is issued on the edge entering READ so it is high for exactly that state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_order_err <= 1'b0;
      r_pass_cnt  <= '0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= FIRST_IDX;
          if (sort_done) begin
            r_order_err <= 1'b0;
            r_rd_en     <= 1'b1;
            r_rd_addr   <= FIRST_IDX;
          end
        end
        S_CAPT: begin
          r_out_data  <= rd_data;
          r_out_valid <= 1'b1;
          r_out_last  <= w_is_last;
          if ((r_idx != FIRST_IDX) && w_order_bad) r_order_err <= 1'b1;
        end
        S_HOLD: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_is_last) begin
              r_pass_cnt <= r_pass_cnt + 8'd1;
            end else begin
              r_idx     <= w_idx_step;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_idx_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = w_busy;
  assign order_err = r_order_err;
  assign pass_cnt  = r_pass_cnt;

endmodule
